// File: rtl/fft_pingpong_sram_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_pingpong_sram_buffer_if
// Description : Stream bundle for the FFT ping-pong sample buffer.
//               Write side : wr_valid/wr_ready/wr_data + wr_frame_done pulse
//               Read side  : rd_valid/rd_ready/rd_data/rd_last
//               Status     : frames_avail (full banks not yet fully read)
//               master = producer/consumer environment, slave = the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_pingpong_sram_buffer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_frame_done;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic [1:0]            frames_avail;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, wr_frame_done, rd_valid, rd_data, rd_last, frames_avail
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, wr_frame_done, rd_valid, rd_data, rd_last, frames_avail
    );
endinterface
`default_nettype wire

// File: rtl/fft_pingpong_sram_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fft_pingpong_sram_buffer
// Description : Two-bank ping-pong sample buffer in front of an FFT core.
//               One bank fills from the write stream while the other drains
//               as a frame to the read stream. Synchronous-read SRAM feeds a
//               2-entry output skid buffer for full-rate, stall-safe output.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous active-high reset
//               clear - synchronous flush of control state (memory untouched)
//               bus   - fft_pingpong_sram_buffer_if.slave stream bundle
// Options     : BIT_REVERSE_READ_EN - when defined, frames are read in
//               bit-reversed address order (radix-2 decimation order).
// Revision    : 1.0 - initial release
// ============================================================================
module fft_pingpong_sram_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   clear,
    fft_pingpong_sram_buffer_if.slave   bus
);
    localparam int                    c_depth     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(c_depth - 1);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } bank_state_t;

    bank_state_t            r_state [2];
    bank_state_t            w_state_nxt [2];

    logic [DATA_WIDTH-1:0]  r_mem [2*c_depth];
    logic [DATA_WIDTH-1:0]  r_sram_q;

    logic                   r_wr_bank;
    logic [ADDR_WIDTH-1:0]  r_wr_cnt;
    logic                   r_wr_frame_done;
    logic                   r_rd_bank;
    logic                   r_fetch_bank;
    logic [ADDR_WIDTH-1:0]  r_fetch_cnt;
    logic                   r_fetch_active;
    logic                   r_inflight;
    logic                   r_inflight_last;
    logic [DATA_WIDTH-1:0]  r_skid_data [2];
    logic                   r_skid_last [2];
    logic                   r_skid_wptr;
    logic                   r_skid_rptr;
    logic [1:0]             r_skid_cnt;
    logic [1:0]             r_frames;

    logic                   w_flush;
    logic                   w_wr_ready;
    logic                   w_wr_fire;
    logic                   w_wr_last;
    logic                   w_rd_valid;
    logic                   w_rd_fire;
    logic                   w_rd_last_fire;
    logic [2:0]             w_occupancy;
    logic                   w_fetch;
    logic [ADDR_WIDTH-1:0]  w_rd_addr;

    assign w_flush        = rst | clear;
    assign w_wr_ready     = (r_state[r_wr_bank] == ST_EMPTY) || (r_state[r_wr_bank] == ST_FILLING);
    assign w_wr_fire      = bus.wr_valid && w_wr_ready && !w_flush;
    assign w_wr_last      = w_wr_fire && (r_wr_cnt == c_last_addr);
    assign w_rd_valid     = (r_skid_cnt != 2'd0);
    assign w_rd_fire      = w_rd_valid && bus.rd_ready && !w_flush;
    assign w_rd_last_fire = w_rd_fire && r_skid_last[r_skid_rptr];

    // Credit check: the word in flight out of the SRAM plus what stays in
    // the skid buffer after this cycle's pop must leave room for one more.
    assign w_occupancy = 3'(r_inflight) + 3'(r_skid_cnt) - 3'(w_rd_fire);
    // The fetch bank pointer runs ahead of r_rd_bank so the next full bank
    // can be fetched while the previous frame's tail is still in the skid.
    assign w_fetch     = (r_fetch_active || (r_state[r_fetch_bank] == ST_FULL))
                         && (w_occupancy < 3'd2) && !w_flush;

`ifdef BIT_REVERSE_READ_EN
    for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_bitrev
        assign w_rd_addr[i] = r_fetch_cnt[ADDR_WIDTH-1-i];
    end
`else
    assign w_rd_addr = r_fetch_cnt;
`endif

    // SRAM: one write port, one synchronous read port, no reset.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[{r_wr_bank, r_wr_cnt}] <= bus.wr_data;
        end
        if (w_fetch) begin
            r_sram_q <= r_mem[{r_fetch_bank, w_rd_addr}];
        end
    end

    // Per-bank state machine.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (w_flush) begin
                r_state[b] <= ST_EMPTY;
            end else begin
                r_state[b] <= w_state_nxt[b];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            if (w_wr_fire && (r_wr_bank == 1'(b))) begin
                if (w_wr_last) begin
                    w_state_nxt[b] = ST_FULL;
                end else if (r_state[b] == ST_EMPTY) begin
                    w_state_nxt[b] = ST_FILLING;
                end
            end
            if (w_fetch && (r_fetch_bank == 1'(b)) && (r_state[b] == ST_FULL)) begin
                w_state_nxt[b] = ST_DRAINING;
            end
            if (w_rd_last_fire && (r_rd_bank == 1'(b))) begin
                w_state_nxt[b] = ST_EMPTY;
            end
        end
    end

    // Control datapath: counters, fetch pipeline, skid buffer, frame count.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wr_bank       <= 1'b0;
            r_wr_cnt        <= '0;
            r_wr_frame_done <= 1'b0;
            r_rd_bank       <= 1'b0;
            r_fetch_bank    <= 1'b0;
            r_fetch_cnt     <= '0;
            r_fetch_active  <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_skid_data[0]  <= '0;
            r_skid_data[1]  <= '0;
            r_skid_last[0]  <= 1'b0;
            r_skid_last[1]  <= 1'b0;
            r_skid_wptr     <= 1'b0;
            r_skid_rptr     <= 1'b0;
            r_skid_cnt      <= 2'd0;
            r_frames        <= 2'd0;
        end else begin
            if (w_wr_fire) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            r_wr_frame_done <= w_wr_last;

            r_inflight      <= w_fetch;
            r_inflight_last <= w_fetch && (r_fetch_cnt == c_last_addr);
            if (w_fetch) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
                if (r_fetch_cnt == c_last_addr) begin
                    r_fetch_active <= 1'b0;
                    r_fetch_bank   <= ~r_fetch_bank;
                end else begin
                    r_fetch_active <= 1'b1;
                end
            end

            if (r_inflight) begin
                r_skid_data[r_skid_wptr] <= r_sram_q;
                r_skid_last[r_skid_wptr] <= r_inflight_last;
                r_skid_wptr              <= ~r_skid_wptr;
            end
            if (w_rd_fire) begin
                r_skid_rptr <= ~r_skid_rptr;
            end
            r_skid_cnt <= r_skid_cnt + 2'(r_inflight) - 2'(w_rd_fire);

            if (w_rd_last_fire) begin
                r_rd_bank <= ~r_rd_bank;
            end

            case ({w_wr_last, w_rd_last_fire})
                2'b10:   r_frames <= r_frames + 2'd1;
                2'b01:   r_frames <= r_frames - 2'd1;
                default: r_frames <= r_frames;
            endcase
        end
    end

    assign bus.wr_ready      = w_wr_ready;
    assign bus.wr_frame_done = r_wr_frame_done;
    assign bus.rd_valid      = w_rd_valid;
    assign bus.rd_data       = r_skid_data[r_skid_rptr];
    assign bus.rd_last       = w_rd_valid && r_skid_last[r_skid_rptr];
    assign bus.frames_avail  = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_fft_pingpong_sram_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_pingpong_sram_buffer
// Description : Self-checking bench for fft_pingpong_sram_buffer. A frame
//               queue model predicts read data/order, rd_last, wr_ready,
//               frames_avail and wr_frame_done every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_pingpong_sram_buffer;
    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic rst;
    logic clear;

    fft_pingpong_sram_buffer_if #(.DATA_WIDTH(DW)) bus ();

    fft_pingpong_sram_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: fq holds complete frames in write order, pq the partial frame.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] pq[$];
    int  rd_idx    = 0;
    int  total_rd  = 0;
    int  cyc       = 0;
    bit  exp_done  = 0;
    bit  exp_idle  = 0;
    bit  prev_stall = 0;
    bit  prev_valid = 0;
    logic [DW-1:0] prev_data;
    bit  prev_last;
    bit  last_wr_fire, last_rd_fire;
    int  full_cyc, rise_cyc, first_cyc, last_cyc, gap;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int order(input int k);
`ifdef BIT_REVERSE_READ_EN
        int r = 0;
        for (int i = 0; i < AW; i++) r = r * 2 + ((k >> i) & 1);
        return r;
`else
        return k;
`endif
    endfunction

    // One clock cycle: inputs were set at the preceding negedge.
    task automatic cycle();
        bit wf, rf;
        #1;
        cyc++;
        check("frames_avail", 32'(bus.frames_avail), 32'(fq.size() / DEPTH));
        check("wr_ready", 32'(bus.wr_ready), 32'((fq.size() / DEPTH) < 2));
        check("wr_frame_done", 32'(bus.wr_frame_done), 32'(exp_done));
        if (exp_idle) begin
            check("idle_rd_valid", 32'(bus.rd_valid), 0);
            check("idle_rd_last", 32'(bus.rd_last), 0);
            check("idle_rd_data", 32'(bus.rd_data), 0);
            exp_idle = 0;
        end
        if (prev_stall) begin
            check("hold_valid", 32'(bus.rd_valid), 1);
            check("hold_data", 32'(bus.rd_data), 32'(prev_data));
            check("hold_last", 32'(bus.rd_last), 32'(prev_last));
        end
        if (bus.rd_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = bus.rd_valid;

        wf = bus.wr_valid && bus.wr_ready && !clear;
        rf = bus.rd_valid && bus.rd_ready && !clear;
        exp_done = 0;
        if (rf) begin
            if (fq.size() < DEPTH) begin
                check("rd_spurious", 32'(bus.rd_valid), 0);
            end else begin
                check("rd_data", 32'(bus.rd_data), 32'(fq[order(rd_idx)]));
                check("rd_last", 32'(bus.rd_last), 32'(rd_idx == DEPTH - 1));
                if (rd_idx == 0) begin
                    gap       = cyc - last_cyc;
                    first_cyc = cyc;
                end
                total_rd++;
                rd_idx++;
                if (rd_idx == DEPTH) begin
                    last_cyc = cyc;
                    rd_idx   = 0;
                    for (int i = 0; i < DEPTH; i++) void'(fq.pop_front());
                end
            end
        end
        if (wf) begin
            pq.push_back(bus.wr_data);
            if (pq.size() == DEPTH) begin
                foreach (pq[i]) fq.push_back(pq[i]);
                pq.delete();
                exp_done = 1;
                full_cyc = cyc;
            end
        end
        prev_stall   = bus.rd_valid && !bus.rd_ready && !clear;
        prev_data    = bus.rd_data;
        prev_last    = bus.rd_last;
        last_wr_fire = wf;
        last_rd_fire = rf;
        if (clear) begin
            fq.delete();
            pq.delete();
            rd_idx     = 0;
            exp_done   = 0;
            exp_idle   = 1;
            prev_stall = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_words(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            bus.wr_valid = 1'b1;
            bus.wr_data  = DW'(base + i);
            do begin
                cycle();
                guard++;
            end while (!last_wr_fire && guard < 300);
            if (!last_wr_fire) check("wr_timeout", 32'(last_wr_fire), 1);
        end
        bus.wr_valid = 1'b0;
    endtask

    // mode 0: rd_ready held high; mode 1: rd_ready pattern 1,0,0,1.
    task automatic drain(input int n, input int mode);
        int target = total_rd + n;
        int guard  = 0;
        while (total_rd < target && guard < 3000) begin
            bus.rd_ready = (mode == 0) ? 1'b1 : ((guard % 4) == 0 || (guard % 4) == 3);
            cycle();
            guard++;
        end
        if (total_rd != target) check("drain_timeout", 32'(total_rd), 32'(target));
        bus.rd_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        rst          = 1'b1;
        clear        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        exp_idle = 1;
        cycle();

        // Single frame streamed with the consumer always ready.
        bus.rd_ready = 1'b1;
        write_words(0, DEPTH);
        drain(DEPTH, 0);
        check("first_latency", 32'(rise_cyc - full_cyc - 1), 2);
        check("frame_span", 32'(last_cyc - first_cyc), DEPTH - 1);

        // Two frames queued, extra word refused, then back-to-back drain.
        write_words(0, DEPTH);
        write_words(100, DEPTH);
        check("two_full", 32'(bus.frames_avail), 2);
        bus.wr_valid = 1'b1;
        bus.wr_data  = DW'(999);
        repeat (4) cycle();
        bus.wr_valid = 1'b0;
        drain(2 * DEPTH, 0);
        check("b2b_gap", 32'(gap), 1);
        check("b2b_span", 32'(last_cyc - first_cyc), DEPTH - 1);

        // Backpressure during drain.
        write_words(300, DEPTH);
        drain(DEPTH, 1);

        // Last write of one frame coincides with rd_last acceptance of another.
        write_words(400, DEPTH);
        write_words(500, DEPTH - 1);
        done = 0;
        for (int g = 0; g < 300 && !done; g++) begin
            bus.rd_ready = 1'b1;
            if (bus.rd_valid && bus.rd_last) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = DW'(500 + DEPTH - 1);
                cycle();
                bus.wr_valid = 1'b0;
                check("sc_both_fire", {30'd0, last_wr_fire, last_rd_fire}, 3);
                check("sc_frames", 32'(bus.frames_avail), 1);
                check("sc_wr_ready", 32'(bus.wr_ready), 1);
                done = 1;
            end else begin
                cycle();
            end
        end
        if (!done) check("sc_timeout", 32'(done), 1);
        drain(DEPTH, 0);

        // Clear mid-write, then clear mid-drain, then a fresh frame.
        write_words(600, 20);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();
        write_words(800, DEPTH);
        drain(10, 0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();
        bus.rd_ready = 1'b1;
        write_words(200, DEPTH);
        drain(DEPTH, 0);

        // Randomized traffic on both sides.
        for (int i = 0; i < 1200; i++) begin
            bus.wr_valid = 1'($urandom_range(0, 3) != 0);
            bus.wr_data  = DW'($urandom);
            bus.rd_ready = 1'($urandom_range(0, 2) != 0);
            cycle();
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b1;
        repeat (200) cycle();
        check("final_frames", 32'(bus.frames_avail), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
